// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream multiplexer/arbiter.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Explicit compare so non-power-of-2 channel counts wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N producer streams, the mux, and one consumer.
interface stream_mux_arb_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = $clog2(NCH);

    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_chan;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_arb_pick.sv
// Round-robin priority picker: first requester at or after ptr_i, wrapping.
module rr_priority_pick #(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            grant_valid_o
);
    logic [SELW:0] idx_s;
    logic          hit_s;

    // Scan NCH positions starting at the pointer; the first hit wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx_s         = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx_s         = {1'b0, ptr_i} + (SELW+1)'(k);
            idx_s         = (idx_s >= (SELW+1)'(NCH)) ? (idx_s - (SELW+1)'(NCH)) : idx_s;
            hit_s         = !grant_valid_o && req_i[idx_s[SELW-1:0]];
            grant_o       = hit_s ? idx_s[SELW-1:0] : grant_o;
            grant_valid_o = grant_valid_o | hit_s;
        end
    end
endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream mux with registered output; fixed-select or round-robin grant.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    localparam int SELW = $clog2(NCH)
) (
    input logic             clk,
    input logic             reset,
    stream_mux_arb_if.slave bus
);
    logic              load_en_s;
    logic [SELW-1:0]   rr_grant_s;
    logic              rr_grant_valid_s;
    logic [SELW-1:0]   cand_s;
    logic              cand_valid_s;
    logic [NCH-1:0]    in_ready_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  data_sel_s;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SELW-1:0]   out_chan_q,  out_chan_d;
    logic [SELW-1:0]   ptr_q,       ptr_d;

    rr_priority_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
        .req_i         (bus.in_valid),
        .ptr_i         (ptr_q),
        .grant_o       (rr_grant_s),
        .grant_valid_o (rr_grant_valid_s)
    );

    // Candidate channel from the active selection mode.
    always_comb begin
        load_en_s    = !out_valid_q || bus.out_ready;
        cand_s       = '0;
        cand_valid_s = 1'b0;
        if (bus.mode == MODE_RR) begin
            cand_s       = rr_grant_s;
            cand_valid_s = rr_grant_valid_s;
        end else begin
            cand_s       = bus.sel;
            cand_valid_s = ({1'b0, bus.sel} < (SELW+1)'(NCH));
        end
    end

    // One-hot ready and AND-OR data select; ready stays low through reset.
    always_comb begin
        in_ready_s = '0;
        data_sel_s = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready_s[i] = !reset && load_en_s && cand_valid_s && (cand_s == SELW'(i));
            data_sel_s    = data_sel_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{in_ready_s[i]}});
        end
        xfer_s = |(in_ready_s & bus.in_valid);
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = load_en_s ? xfer_s : out_valid_q;
        out_data_d  = xfer_s ? data_sel_s : out_data_q;
        out_chan_d  = xfer_s ? cand_s : out_chan_q;
        ptr_d       = (xfer_s && (bus.mode == MODE_RR))
                    ? SELW'(wrap_inc(int'(cand_s), NCH)) : ptr_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule
